ula_ctrl_fsm: RTL and testbench
===============================

Name: ula_ctrl_fsm

Overview:
- Multicycle control unit that drives the ALU: decodes opcode/funct and sequences fetch, decode, execute, memory and writeback.
- Produces the 4-bit ALU operation code the ALU consumes, plus all datapath mux selects and write strobes.
- Sits between the instruction register and the datapath. Consumes the ALU Zero_flag for branch resolution.

Parameters:
- RESET_PC_HOLD, 1, cycles spent in IDLE after reset release before the first FETCH (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU Zero_flag
- alu_op  out  4  ALU operation code
- alu_src_a  out  1  0=PC, 1=reg A
- alu_src_b  out  2  00=reg B, 01=const 4, 10=ext imm, 11=sext imm<<2
- ext_zero  out  1  1=zero-extend imm (andi/ori/xori), 0=sign-extend
- shamt_sel  out  1  1=ALU shamt from IR[10:6] (sll/srl/sra)
- iord  out  1  0=mem addr from PC, 1=from ALUOut
- mem_read / mem_write  out  1 each  memory strobes
- ir_write  out  1  load IR
- reg_write  out  1  register file write
- reg_dst  out  1  1=rd, 0=rt
- mem_to_reg  out  1  1=MDR, 0=ALUOut
- pc_write  out  1  PC load (unconditional or resolved branch)
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct

Behaviour:
- The state register is the only storage besides the IDLE counter. Outputs are decoded combinationally from state, opcode, funct and zero.
- Async reset: state=IDLE, counter=0. All outputs are 0 while in IDLE, including alu_op=0000.
- IDLE: stay RESET_PC_HOLD cycles, then go to FETCH.
- FETCH: mem_read, ir_write, alu_src_a=0, alu_src_b=01, alu_op=ADD(0010), pc_source=00, pc_write. Next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target to ALUOut). Next state by opcode:
  - 0x00 → EXEC_R
  - lw 0x23 / sw 0x2B → MEM_ADDR
  - beq 0x04 / bne 0x05 → BRANCH
  - j 0x02 → JUMP
  - 0x08–0x0F → EXEC_I
  - anything else → FETCH with illegal=1 and instr_done=1.
- EXEC_R: alu_src_a=1, alu_src_b=00, shamt_sel=1 for funct 00/02/03. alu_op by funct:
  - 20,21→0010; 22,23→0110; 24→0000; 25→0001; 26→1101; 27→1100
  - 2A→0111; 2B→1000; 00→0011; 02→0101; 03→0100
  - 04→1110; 06→1111; 07→1010
  - Unknown funct: illegal=1, instr_done=1, next state FETCH, no writeback.
  - Otherwise next state RTYPE_WB.
- RTYPE_WB: reg_write, reg_dst=1, mem_to_reg=0, instr_done. Next state FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10. ext_zero=1 for 0C/0D/0E. alu_op by opcode:
  - 08,09→0010; 0A→0111; 0B→1000; 0C→0000; 0D→0001; 0E→1101; 0F→1011
  - Next state ITYPE_WB.
- ITYPE_WB: reg_write, reg_dst=0, mem_to_reg=0, instr_done. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0010. Next state MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read, iord=1. Next state MEM_WB.
- MEM_WB: reg_write, reg_dst=0, mem_to_reg=1, instr_done. Next state FETCH.
- MEM_WRITE: mem_write, iord=1, instr_done. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB(0110), pc_source=01. pc_write=zero for beq, ~zero for bne. instr_done. Next state FETCH.
- JUMP: pc_source=10, pc_write, instr_done. Next state FETCH.
- Cycle counts: R/I-type/sw = 4, lw = 5, branch/jump = 3.
- Reset asserted mid-instruction: strobes drop immediately to 0 (async). No partial writeback completes after rst_n is asserted.
- reg_write, mem_write and pc_write must never be asserted in the same cycle.

Decomposition:
- Shared package ula_pkg holds:
  - ALU opcode constants (ALU_AND=0000 … ALU_SRAV=1010)
  - MIPS opcode/funct constants
  - state enum typedef
  - alu_src_b encoding constants
- Natural sub-module: ula_op_decode, a combinational opcode/funct → alu_op/shamt_sel/ext_zero/legal mapping reused by EXEC_R and EXEC_I.

Test Plan:
- Reset held 3 cycles, then release with RESET_PC_HOLD=1 → all outputs 0 during reset; FETCH on the 2nd edge after release with alu_op=0010, pc_write=1.
- R-type sub (op 00, funct 22) → states FETCH, DECODE, EXEC_R (alu_op=0110), RTYPE_WB (reg_write=1, reg_dst=1); instr_done on cycle 4.
- lw (0x23) → 5 cycles; MEM_READ has iord=1, mem_read=1; MEM_WB has mem_to_reg=1, reg_dst=0.
- beq with zero=1 → pc_write=1, pc_source=01 in BRANCH. Then bne with zero=1 → pc_write=0.
- ori (0x0D) → alu_op=0001, ext_zero=1. sra funct 03 → alu_op=0100, shamt_sel=1. Opcode 0x3F → illegal pulse in DECODE, return to FETCH.
- rst_n asserted during RTYPE_WB → reg_write drops within the same cycle; IDLE restarts.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared ALU codes, MIPS opcode/funct values, mux encodings and FSM state type
package ula_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRA  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRAV = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;
  localparam logic [3:0] ALU_SLLV = 4'b1110;
  localparam logic [3:0] ALU_SRLV = 4'b1111;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_BR   = 2'b11;
  localparam logic [1:0] PC_SRC_ALU = 2'b00;
  localparam logic [1:0] PC_SRC_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_RTYPE_WB, S_EXEC_I, S_ITYPE_WB,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP
  } state_t;
endpackage

// File: rtl/ula_op_decode.sv
// ula_op_decode: maps funct (is_r=1) or I-type opcode (is_r=0) to alu_op, shamt_sel, ext_zero and legal
module ula_op_decode
  import ula_pkg::*;
(
  input  logic       is_r,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       shamt_sel,
  output logic       ext_zero,
  output logic       legal
);
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    if (is_r)
      case (funct)
        F_ADD, F_ADDU: alu_op = ALU_ADD;
        F_SUB, F_SUBU: alu_op = ALU_SUB;
        F_AND:         alu_op = ALU_AND;
        F_OR:          alu_op = ALU_OR;
        F_XOR:         alu_op = ALU_XOR;
        F_NOR:         alu_op = ALU_NOR;
        F_SLT:         alu_op = ALU_SLT;
        F_SLTU:        alu_op = ALU_SLTU;
        F_SLL:         alu_op = ALU_SLL;
        F_SRL:         alu_op = ALU_SRL;
        F_SRA:         alu_op = ALU_SRA;
        F_SLLV:        alu_op = ALU_SLLV;
        F_SRLV:        alu_op = ALU_SRLV;
        F_SRAV:        alu_op = ALU_SRAV;
        default:       legal  = 1'b0;
      endcase
    else
      case (opcode)
        OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
        OP_SLTI:           alu_op = ALU_SLT;
        OP_SLTIU:          alu_op = ALU_SLTU;
        OP_ANDI:           alu_op = ALU_AND;
        OP_ORI:            alu_op = ALU_OR;
        OP_XORI:           alu_op = ALU_XOR;
        OP_LUI:            alu_op = ALU_LUI;
        default:           legal  = 1'b0;
      endcase
  end
  assign shamt_sel = is_r && (funct == F_SLL || funct == F_SRL || funct == F_SRA);
  assign ext_zero  = !is_r && (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI);
endmodule

// File: rtl/ula_ctrl_fsm.sv
// ula_ctrl_fsm: multicycle MIPS control FSM; in clk, rst_n, opcode, funct, zero; out alu_op, datapath selects, strobes, instr_done, illegal
module ula_ctrl_fsm
  import ula_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic       shamt_sel,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal
);
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] d_alu;
  logic d_shamt, d_ext, d_legal;
  ula_op_decode u_dec (
    .is_r(state == S_EXEC_R), .opcode(opcode), .funct(funct),
    .alu_op(d_alu), .shamt_sel(d_shamt), .ext_zero(d_ext), .legal(d_legal)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_IDLE) ? cnt + 4'd1 : cnt;
    end
  always_comb begin
    state_nxt  = state;
    alu_op     = '0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    ext_zero   = 1'b0;
    shamt_sel  = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    pc_source  = PC_SRC_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE: state_nxt = (cnt == 4'(RESET_PC_HOLD)) ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
        pc_write  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b  = SRC_B_BR;
        alu_op     = ALU_ADD;
        state_nxt  = (opcode == OP_RTYPE) ? S_EXEC_R :
                     (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                     (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
                     (opcode == OP_J) ? S_JUMP :
                     (opcode[5:3] == 3'b001) ? S_EXEC_I : S_FETCH;
        illegal    = (state_nxt == S_FETCH);
        instr_done = illegal;
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = d_alu;
        shamt_sel  = d_shamt;
        illegal    = !d_legal;
        instr_done = !d_legal;
        state_nxt  = d_legal ? S_RTYPE_WB : S_FETCH;
      end
      S_RTYPE_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = d_alu;
        ext_zero  = d_ext;
        state_nxt = S_ITYPE_WB;
      end
      S_ITYPE_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
        state_nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_source  = PC_SRC_OUT;
        pc_write   = (opcode == OP_BEQ) ? zero : !zero;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = PC_SRC_JMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ula_ctrl_fsm.sv
// tb_ula_ctrl_fsm: scoreboard bench comparing per-instruction control behaviour against an instruction-level model
module tb_ula_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0;
  logic [3:0] alu_op;
  logic alu_src_a, ext_zero, shamt_sel, iord, mem_read, mem_write, ir_write;
  logic reg_write, reg_dst, mem_to_reg, pc_write, instr_done, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [20:0] outv;
  ula_ctrl_fsm #(.RESET_PC_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .shamt_sel(shamt_sel), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .pc_write(pc_write), .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal)
  );
  assign outv = {alu_op, alu_src_a, alu_src_b, ext_zero, shamt_sel, iord, mem_read, mem_write,
                 ir_write, reg_write, reg_dst, mem_to_reg, pc_write, pc_source, instr_done, illegal};
  always #5 clk = ~clk;
  int checks = 0, passed = 0;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask
  typedef struct {
    int cyc, ill, alu, chk_alu, rw, mw, pw, io, mr, rd, m2r, ez, ss;
  } exp_t;
  exp_t sb[$];
  function automatic int r_alu(logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return 2;
      6'h22, 6'h23: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h26: return 13;
      6'h27: return 12;
      6'h2A: return 7;
      6'h2B: return 8;
      6'h00: return 3;
      6'h02: return 5;
      6'h03: return 4;
      6'h04: return 14;
      6'h06: return 15;
      6'h07: return 10;
      default: return -1;
    endcase
  endfunction
  function automatic int i_alu(logic [5:0] op);
    case (op)
      6'h08, 6'h09: return 2;
      6'h0A: return 7;
      6'h0B: return 8;
      6'h0C: return 0;
      6'h0D: return 1;
      6'h0E: return 13;
      default: return 11;
    endcase
  endfunction
  function automatic exp_t model(logic [5:0] op, logic [5:0] fn, logic z);
    exp_t e = '{default: 0};
    int a;
    e.pw = 1;
    e.mr = 1;
    e.chk_alu = 1;
    a = r_alu(fn);
    if (op == 6'h00 && a < 0) begin
      e.cyc = 3; e.ill = 1; e.chk_alu = 0;
    end else if (op == 6'h00) begin
      e.cyc = 4; e.alu = a; e.rw = 1; e.rd = 1; e.ss = int'(fn <= 6'h03 && fn != 6'h01);
    end else if (op >= 6'h08 && op <= 6'h0F) begin
      e.cyc = 4; e.alu = i_alu(op); e.rw = 1; e.ez = int'(op >= 6'h0C && op <= 6'h0E);
    end else if (op == 6'h23) begin
      e.cyc = 5; e.alu = 2; e.rw = 1; e.io = 1; e.mr = 2; e.m2r = 1;
    end else if (op == 6'h2B) begin
      e.cyc = 4; e.alu = 2; e.mw = 1; e.io = 1;
    end else if (op == 6'h04 || op == 6'h05) begin
      e.cyc = 3; e.alu = 6; e.pw += (op == 6'h04) ? int'(z) : int'(!z);
    end else if (op == 6'h02) begin
      e.cyc = 3; e.alu = 0; e.pw = 2;
    end else begin
      e.cyc = 2; e.ill = 1; e.chk_alu = 0;
    end
    return e;
  endfunction
  logic mon_en = 1'b0;
  int cyc, ill, alu, rw, mw, pw, io, mr, rd, m2r, ez, ss, excl;
  always @(negedge clk)
    if (mon_en && rst_n) begin
      if (ir_write) begin
        cyc = 0; ill = 0; alu = 0; rw = 0; mw = 0; pw = 0; io = 0; mr = 0;
        rd = 0; m2r = 0; ez = 0; ss = 0; excl = 0;
      end
      cyc++;
      ill += int'(illegal);
      if (cyc == 3) alu = int'(alu_op);
      rw += int'(reg_write);
      mw += int'(mem_write);
      pw += int'(pc_write);
      io += int'(iord);
      mr += int'(mem_read);
      if (reg_write) begin rd = int'(reg_dst); m2r = int'(mem_to_reg); end
      ez |= int'(ext_zero);
      ss |= int'(shamt_sel);
      if (int'(reg_write) + int'(mem_write) + int'(pc_write) > 1) excl++;
      if (instr_done) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: actual=done required=no pending instruction");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("cycles", cyc, e.cyc);
          chk("illegal", ill, e.ill);
          if (e.chk_alu != 0) chk("exec_alu_op", alu, e.alu);
          chk("reg_write", rw, e.rw);
          chk("mem_write", mw, e.mw);
          chk("pc_write", pw, e.pw);
          chk("iord", io, e.io);
          chk("mem_read", mr, e.mr);
          chk("reg_dst", rd, e.rd);
          chk("mem_to_reg", m2r, e.m2r);
          chk("ext_zero", ez, e.ez);
          chk("shamt_sel", ss, e.ss);
          chk("write_exclusive", excl, 0);
        end
      end
    end
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z);
    int n = 0;
    sb.push_back(model(op, fn, z));
    opcode = op;
    funct = fn;
    zero = z;
    do begin @(negedge clk); n++; end while (!instr_done && n < 20);
    if (!instr_done) begin
      checks++;
      $display("FAIL done_timeout: actual=no instr_done in 20 cycles required=instr_done op=%0h", op);
    end
    @(posedge clk);
    #1;
  endtask
  logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                           6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
  logic [5:0] fns [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  initial begin
    logic [5:0] op, fn;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", int'(outv), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold_outputs_zero", int'(outv), 0);
    mon_en = 1'b1;
    fork
      begin
        @(negedge clk);
        chk("first_fetch_alu_op", int'(alu_op), 2);
        chk("first_fetch_pc_write", int'(pc_write), 1);
        chk("first_fetch_ir_write", int'(ir_write), 1);
      end
    join_none
    run_instr(6'h00, 6'h22, 1'b0);
    run_instr(6'h23, 6'h00, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1);
    run_instr(6'h05, 6'h00, 1'b1);
    run_instr(6'h0D, 6'h00, 1'b0);
    run_instr(6'h00, 6'h03, 1'b0);
    run_instr(6'h3F, 6'h00, 1'b0);
    run_instr(6'h00, 6'h01, 1'b0);
    run_instr(6'h2B, 6'h11, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0);
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      run_instr(op, fn, 1'($urandom));
    end
    chk("scoreboard_drained", sb.size(), 0);
    mon_en = 1'b0;
    opcode = 6'h00;
    funct = 6'h20;
    n = 0;
    do begin @(negedge clk); n++; end while (!reg_write && n < 10);
    chk("reach_rtype_wb", int'(reg_write), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_reg_write", int'(reg_write), 0);
    chk("reset_mid_outputs_zero", int'(outv), 0);
    @(posedge clk);
    #1;
    chk("reset_held_outputs_zero", int'(outv), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_idle_zero", int'(outv), 0);
    @(negedge clk);
    chk("restart_fetch_ir_write", int'(ir_write), 1);
    chk("restart_fetch_alu_op", int'(alu_op), 2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
